fabric_config_loader: RTL
=========================

// Module: fabric_config_loader
// PURPOSE
//   Serial bitstream loader for the fabric. Sits directly upstream of the logic_tile and switch_box_4x4 arrays.
//   Hunts for a sync word, shifts the payload into a shadow register, then checks one even-parity bit.
//   On a good load, commits the payload in one cycle onto parallel buses: tile_cfg (each tile's mem[32:0]) and sw_cfg (each box's configure[15:0]).
//   A bad load never disturbs the live fabric configuration.
// PARAMETERS
//   NUM_TILES     8       number of logic tiles driven
//   NUM_SWITCHES  2       number of 4x4 switch boxes driven
//   TILE_BITS     33      config bits per tile (32 LUT bits + bit32 registered/comb select)
//   SWITCH_BITS   16      config bits per switch box
//   SYNC_WORD     8'hA5   preamble marking start of payload
// PORTS
//   clock       in   1                         rising-edge clock
//   reset       in   1                         asynchronous, active-high
//   start       in   1                         1-cycle request to begin/restart a load
//   bit_in      in   1                         serial bitstream data
//   bit_valid   in   1                         bit_in valid; a bit is accepted when bit_valid && ready
//   ready       out  1                         loader accepting bits
//   busy        out  1                         a load is in progress
//   done        out  1                         1-cycle pulse on successful commit
//   error       out  1                         parity failure; held until next start
//   cfg_valid   out  1                         tile_cfg/sw_cfg hold a committed configuration
//   tile_cfg    out  NUM_TILES*TILE_BITS       tile i = tile_cfg[i*TILE_BITS +: TILE_BITS]
//   sw_cfg      out  NUM_SWITCHES*SWITCH_BITS  box j = sw_cfg[j*SWITCH_BITS +: SWITCH_BITS]
// BEHAVIOUR
//   P = NUM_TILES*TILE_BITS + NUM_SWITCHES*SWITCH_BITS (default 296).
//   Reset (async, any state): state=IDLE; all outputs 0, including tile_cfg, sw_cfg, cfg_valid; shadow and counters 0.
//   FSM states: IDLE, SYNC, LOAD, PARITY, DONE, ERROR.
//   IDLE:   ready=0, busy=0. start -> SYNC.
//   SYNC:   ready=1, busy=1. Accepted bits enter an 8-bit window, MSB first (win <= {win[6:0],bit_in}).
//           Go to LOAD in the cycle the window, including the bit just accepted, equals SYNC_WORD.
//           Overlapping hunts are allowed, e.g. ...A A5 matches. Window is cleared on entry.
//   LOAD:   ready=1. Each accepted bit shifts into the shadow MSB (sh <= {bit_in, sh[P-1:1]}) and bit_cnt increments.
//           After P bits, the first received bit sits at sh[0] = tile0 mem[0].
//           sh[NUM_TILES*TILE_BITS] = switch box 0 configure[0].
//           When bit_cnt reaches P-1 and a bit is accepted -> PARITY.
//           bit_cnt width is $clog2(P+1).
//   PARITY: ready=1. Accepted bit p: if (^sh ^ p)==0 -> DONE, else -> ERROR.
//   DONE:   lasts one cycle. tile_cfg/sw_cfg <= sh; cfg_valid <= 1; done=1. Then -> IDLE.
//           The outputs change on the clock edge leaving PARITY, so done and the new config are visible in the same cycle.
//   ERROR:  error=1, busy=0, ready=0. tile_cfg, sw_cfg and cfg_valid are unchanged. start -> SYNC and clears error.
//   start while in SYNC/LOAD/PARITY: abort and restart SYNC.
//     Window, shadow and bit_cnt are cleared; committed outputs are untouched.
//     start has priority over a bit accepted in the same cycle (that bit is dropped).
//   bit_valid with ready=0: bit ignored, no state change.
//   Gaps in bit_valid: state holds, counters frozen.
//   Reload while cfg_valid=1: the old configuration stays live until the new commit.
//   Minimum load latency: 8 + P + 1 accepted bits, plus 1 commit cycle.
// STRUCTURE
//   Shared package/header: state encodings; default TILE_BITS/SWITCH_BITS; SYNC_WORD.
//     The logic_tile/switch_box config widths are sourced from there.
//   One sub-module: cfg_shift_reg (P-bit right shift register with clear + shift enable, plus running parity).
//     Running parity is an XOR accumulator, which avoids a 296-input reduction.
//   FSM, sync window, bit counter and commit register live in fabric_config_loader.
// TESTING
//   1. Reset mid-LOAD (after 100 payload bits) -> all outputs 0, state IDLE; next start + full stream loads cleanly.
//   2. start; A5; payload with tile0=33'h1_0000_0008, all else 0; parity=0
//      -> done pulse; tile_cfg[32:0]==33'h1_0000_0008; cfg_valid=1.
//   3. Same stream, parity bit flipped -> error=1 held, no done;
//      tile_cfg/sw_cfg equal the prior commit; cfg_valid unchanged.
//   4. Preamble 8'hFA then A5 (bits 11111010 10100101) -> lock only after the final A5 bit;
//      payload of all-ones (parity 0, P even) -> tile_cfg all 1s, sw_cfg 32'hFFFF_FFFF.
//   5. bit_valid toggled randomly 50% during LOAD -> result identical to test 2; bit_cnt frozen on idle cycles.
//   6. start asserted with bit_valid in LOAD at bit 150 -> bit dropped, state SYNC, shadow cleared;
//      old config still live; a full restream commits.

Source files
------------

// File: rtl/fabric_config_loader_pkg.sv
// Shared definitions for the fabric configuration loader and the fabric blocks it feeds.
package fabric_config_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    LOAD   = 3'd2,
    PARITY = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // Config widths of logic_tile (32 LUT bits + reg/comb select) and switch_box_4x4
  localparam int TILE_BITS_DEF   = 33;
  localparam int SWITCH_BITS_DEF = 16;

  // Preamble that marks the start of the payload
  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;

endpackage

// File: rtl/fabric_config_loader_shift.sv
// P-bit right shift register (new bits enter at the MSB) with a running parity
// accumulator, so the parity check never needs a full-width reduction.
module cfg_shift_reg #(
  parameter int P = 296
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         shift,
  input  logic         bit_in,
  output logic [P-1:0] data,
  output logic         parity
);

  // Clear wins over shift; parity tracks XOR of every bit currently held
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data   <= '0;
      parity <= 1'b0;
    end else if (clear) begin
      data   <= '0;
      parity <= 1'b0;
    end else if (shift) begin
      data   <= {bit_in, data[P-1:1]};
      parity <= parity ^ bit_in;
    end
  end

endmodule

// File: rtl/fabric_config_loader.sv
// Serial bitstream loader: hunts for the sync word, shifts in the payload,
// checks one even-parity bit and commits tile/switch configuration atomically.
module fabric_config_loader
  import fabric_config_loader_pkg::*;
#(
  parameter int         NUM_TILES    = 8,
  parameter int         NUM_SWITCHES = 2,
  parameter int         TILE_BITS    = TILE_BITS_DEF,
  parameter int         SWITCH_BITS  = SWITCH_BITS_DEF,
  parameter logic [7:0] SYNC_WORD    = SYNC_WORD_DEF
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                bit_in,
  input  logic                                bit_valid,
  output logic                                ready,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic                                cfg_valid,
  output logic [NUM_TILES*TILE_BITS-1:0]      tile_cfg,
  output logic [NUM_SWITCHES*SWITCH_BITS-1:0] sw_cfg
);

  localparam int TP = NUM_TILES * TILE_BITS;
  localparam int P  = TP + NUM_SWITCHES * SWITCH_BITS;
  localparam int CW = $clog2(P + 1);

  state_t          state;
  // Only the 7 most recent bits need storing; the 8th window bit is bit_in itself
  logic [6:0]      hist;
  logic [7:0]      win_nxt;
  logic [CW-1:0]   bit_cnt;
  logic [P-1:0]    sh;
  logic            par;
  logic            accept;
  logic            restart;
  logic            shift;

  // start aborts/launches a load from any state except the single commit cycle,
  // and takes priority over a bit presented in the same cycle
  assign restart = start && (state != DONE);
  assign accept  = bit_valid && ready && !start;
  assign shift   = accept && (state == LOAD);
  assign win_nxt = {hist, bit_in};

  cfg_shift_reg #(.P(P)) u_shift (
    .clock  (clock),
    .reset  (reset),
    .clear  (restart),
    .shift  (shift),
    .bit_in (bit_in),
    .data   (sh),
    .parity (par)
  );

  // Loader FSM with registered handshake/status outputs and the commit register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hist      <= '0;
      bit_cnt   <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cfg_valid <= 1'b0;
      tile_cfg  <= '0;
      sw_cfg    <= '0;
    end else begin
      done <= 1'b0;
      if (restart) begin
        state   <= SYNC;
        hist    <= '0;
        bit_cnt <= '0;
        ready   <= 1'b1;
        busy    <= 1'b1;
        error   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          SYNC: if (accept) begin
            hist <= win_nxt[6:0];
            if (win_nxt == SYNC_WORD) state <= LOAD;
          end
          LOAD: if (accept) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(P - 1)) state <= PARITY;
          end
          PARITY: if (accept) begin
            ready <= 1'b0;
            busy  <= 1'b0;
            if (par ^ bit_in) begin
              // Bad load: live configuration is left untouched
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state     <= DONE;
              done      <= 1'b1;
              cfg_valid <= 1'b1;
              tile_cfg  <= sh[TP-1:0];
              sw_cfg    <= sh[P-1:TP];
            end
          end
          DONE:    state <= IDLE;
          ERROR:   ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
